// File: rtl/slink_wr_arb_pkg.sv
// Shared sync-link constants: arbiter state encoding, timing defaults,
// done-marker values and the write-beat record used on the AFPGA port.
package slink_wr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    localparam logic [12:0] HOLD_MAX_DEF = 13'd4100;
    localparam logic [1:0]  GAP_CYC_DEF  = 2'd1;

    // Done marker written by the local status writer at the end of a frame.
    localparam logic [22:0] DONE_ADDR = 23'd2050;
    localparam logic [7:0]  DONE_DATA = 8'd34;

    typedef struct packed {
        logic        wen;
        logic [22:0] waddr;
        logic [7:0]  wdata;
    } slink_wr_t;

    localparam slink_wr_t WR_IDLE = '0;

    // IDLE arbitration: a lone requester wins; on a tie the requester that
    // was not served last wins.
    function automatic arb_state_t pick_grant(
        input logic req0,
        input logic req1,
        input logic last_id
    );
        arb_state_t result;
        result = ST_IDLE;
        if (req0 && (!req1 || last_id)) begin
            result = ST_GNT0;
        end else if (req1) begin
            result = ST_GNT1;
        end
        return result;
    endfunction

endpackage

// File: rtl/slink_wr_arb_hold_timer.sv
// Grant-duration counter: cleared while no grant is active, counts grant
// cycles, and flags the cycle in which the grant reaches its limit.
module slink_hold_timer
    import slink_wr_arb_pkg::*;
#(
    parameter logic [12:0] TERM = HOLD_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [12:0] cnt;

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 13'd1;
        end
    end

    // cnt is 0 in the first granted cycle, so TERM-1 marks the TERM-th one.
    assign term = en && (cnt == TERM - 13'd1);

endmodule

// File: rtl/slink_wr_arb.sv
// Two-requester write arbiter for the sync-link AFPGA write port, with a
// bounded grant duration and an enforced idle gap between grants.
module slink_wr_arb
    import slink_wr_arb_pkg::*;
#(
    parameter logic [12:0] HOLD_MAX = HOLD_MAX_DEF,
    parameter logic [1:0]  GAP_CYC  = GAP_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        wen0,
    input  logic        wen1,
    input  logic [22:0] waddr0,
    input  logic [22:0] waddr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        slink_wen,
    output logic [22:0] slink_waddr,
    output logic [7:0]  slink_data,
    output logic        hold_err,
    output logic        err_src
);

    // A zero gap setting still spends one cycle in GAP.
    localparam logic [1:0] GAP_LAST = (GAP_CYC == 2'd0) ? 2'd0 : GAP_CYC - 2'd1;

    arb_state_t state, state_nxt;
    logic       last_id;
    logic [1:0] gap_cnt;
    logic       in_gnt;
    logic       gnt_id;
    logic       owner_req;
    logic       hold_term;
    logic       forced_rel;
    slink_wr_t  wr0, wr1, wr_sel, bus_q;

    assign wr0       = {wen0, waddr0, wdata0};
    assign wr1       = {wen1, waddr1, wdata1};
    assign in_gnt    = (state == ST_GNT0) || (state == ST_GNT1);
    assign gnt_id    = (state == ST_GNT1);
    assign wr_sel    = gnt_id ? wr1 : wr0;
    assign owner_req = gnt_id ? req1 : req0;

    slink_hold_timer #(
        .TERM (HOLD_MAX)
    ) u_hold_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_gnt),
        .en    (in_gnt),
        .term  (hold_term)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        forced_rel = 1'b0;
        unique case (state)
            ST_IDLE: state_nxt = pick_grant(req0, req1, last_id);
            ST_GNT0, ST_GNT1: begin
                // A release on the limit cycle is a normal release.
                if (!owner_req) begin
                    state_nxt = ST_GAP;
                end else if (hold_term) begin
                    state_nxt  = ST_GAP;
                    forced_rel = 1'b1;
                end
            end
            ST_GAP: if (gap_cnt >= GAP_LAST) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_id  <= 1'b1;
            gap_cnt  <= 2'd0;
            hold_err <= 1'b0;
            err_src  <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            bus_q    <= WR_IDLE;
        end else begin
            gnt0    <= (state_nxt == ST_GNT0);
            gnt1    <= (state_nxt == ST_GNT1);
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 2'd1 : 2'd0;

            // Only the current owner is forwarded; the beat sampled on a
            // forced-release cycle is dropped, a normal release keeps it.
            if (in_gnt && !forced_rel) begin
                bus_q <= wr_sel;
            end else begin
                bus_q <= WR_IDLE;
            end

            if (in_gnt && (state_nxt == ST_GAP)) begin
                last_id <= gnt_id;
            end

            if (forced_rel) begin
                hold_err <= 1'b1;
                err_src  <= gnt_id;
            end
        end
    end

    assign slink_wen   = bus_q.wen;
    assign slink_waddr = bus_q.waddr;
    assign slink_data  = bus_q.wdata;

endmodule

// File: tb/tb_slink_wr_arb.sv
// Self-checking bench for slink_wr_arb: directed scenarios plus a random
// phase, all compared cycle by cycle against a transaction-level model.
module tb_slink_wr_arb;

    localparam int          HOLD    = 4100;
    localparam int          GAP     = 1;
    localparam logic [22:0] MK_ADDR = 23'd2050;
    localparam logic [7:0]  MK_DATA = 8'd34;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, wen0, wen1;
    logic [22:0] waddr0, waddr1;
    logic [7:0]  wdata0, wdata1;
    logic        gnt0, gnt1, slink_wen, hold_err, err_src;
    logic [22:0] slink_waddr;
    logic [7:0]  slink_data;

    int n_vec = 0;
    int n_err = 0;
    int marker_cnt = 0;

    // Model: who owns the bus (-1 none), how long, remaining gap cycles.
    int          m_owner, m_age, m_gap, m_last;
    logic        m_herr, m_esrc, m_wen;
    logic [22:0] m_addr;
    logic [7:0]  m_data;
    int          frame_left [2];

    slink_wr_arb dut (
        .clk         (clk),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .wen0        (wen0),
        .wen1        (wen1),
        .waddr0      (waddr0),
        .waddr1      (waddr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .slink_wen   (slink_wen),
        .slink_waddr (slink_waddr),
        .slink_data  (slink_data),
        .hold_err    (hold_err),
        .err_src     (err_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic        r, w;
        logic [22:0] a;
        logic [7:0]  d;
        {m_wen, m_addr, m_data} = '0;
        if (reset) begin
            m_owner = -1; m_gap = 0; m_last = 1; m_herr = 1'b0; m_esrc = 1'b0;
            return;
        end
        if (m_owner >= 0) begin
            r = (m_owner == 0) ? req0 : req1;
            w = (m_owner == 0) ? wen0 : wen1;
            a = (m_owner == 0) ? waddr0 : waddr1;
            d = (m_owner == 0) ? wdata0 : wdata1;
            m_age++;
            {m_wen, m_addr, m_data} = {w, a, d};
            if (!r) begin
                m_last = m_owner; m_owner = -1; m_gap = GAP;
            end else if (m_age == HOLD) begin
                m_herr = 1'b1; m_esrc = (m_owner == 1);
                {m_wen, m_addr, m_data} = '0;
                m_last = m_owner; m_owner = -1; m_gap = GAP;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (req0 && req1) begin
            m_owner = 1 - m_last; m_age = 0;
        end else if (req0) begin
            m_owner = 0; m_age = 0;
        end else if (req1) begin
            m_owner = 1; m_age = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("gnt0", 64'(gnt0), 64'(m_owner == 0));
        check("gnt1", 64'(gnt1), 64'(m_owner == 1));
        check("gnt_excl", 64'(gnt0 & gnt1), 64'(0));
        check("slink_wen", 64'(slink_wen), 64'(m_wen));
        check("slink_waddr", 64'(slink_waddr), 64'(m_addr));
        check("slink_data", 64'(slink_data), 64'(m_data));
        check("hold_err", 64'(hold_err), 64'(m_herr));
        check("err_src", 64'(err_src), 64'(m_esrc));
        if (slink_wen && slink_waddr == MK_ADDR && slink_data == MK_DATA) marker_cnt++;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic rand_beat(input int i);
        if (i == 0) begin
            wen0 = 1'($urandom_range(1)); waddr0 = 23'($urandom); wdata0 = 8'($urandom);
        end else begin
            wen1 = 1'($urandom_range(1)); waddr1 = 23'($urandom); wdata1 = 8'($urandom);
        end
    endtask

    initial begin
        bit seen;
        // Reset state
        do_reset();

        // req0 alone: 2048 consecutive writes; the grant-edge beat is ignored
        req0 = 1'b1; wen0 = 1'b1; waddr0 = 23'h7fffff; wdata0 = 8'hee;
        tick();
        check("gnt0_rise", 64'(gnt0), 64'(1));
        for (int i = 0; i < 2048; i++) begin
            wen0 = 1'b1; waddr0 = 23'h300002 + 23'(i); wdata0 = 8'(i);
            tick();
        end
        idle_inputs();
        repeat (4) tick();

        // Simultaneous requests: req0 first, then a gap, then req1
        do_reset();
        req0 = 1'b1; req1 = 1'b1; wen1 = 1'b1; waddr1 = 23'h123; wdata1 = 8'h55;
        tick();
        for (int i = 0; i < 10; i++) begin rand_beat(0); tick(); end
        req0 = 1'b0; wen0 = 1'b1; waddr0 = 23'h44; wdata0 = 8'h99;
        tick();
        wen0 = 1'b0;
        for (int i = 0; i < 6; i++) begin rand_beat(1); tick(); end
        idle_inputs();
        repeat (4) tick();

        // Done marker from req1 held back until its grant, written once
        do_reset();
        marker_cnt = 0;
        req0 = 1'b1;
        tick();
        req1 = 1'b1; wen1 = 1'b1; waddr1 = MK_ADDR; wdata1 = MK_DATA;
        for (int i = 0; i < 20; i++) begin rand_beat(0); tick(); end
        req0 = 1'b0; wen0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = gnt1;
        end
        check("marker_gnt1_seen", 64'(seen), 64'(1));
        tick();
        wen1 = 1'b0; req1 = 1'b0;
        repeat (4) tick();
        check("marker_once", 64'(marker_cnt), 64'(1));

        // Forced release of requester 0 with requester 1 pending
        do_reset();
        for (int c = 0; c < 5000; c++) begin
            req0 = 1'b1; req1 = (c < 4300);
            rand_beat(0); rand_beat(1);
            tick();
        end
        check("forced0_err", 64'(hold_err), 64'(1));
        check("forced0_src", 64'(err_src), 64'(0));
        idle_inputs();
        repeat (4) tick();

        // Forced release of requester 1, re-grant, then reset mid-frame
        do_reset();
        for (int c = 0; c < 4120; c++) begin
            req1 = 1'b1; rand_beat(1);
            tick();
        end
        check("forced1_src", 64'(err_src), 64'(1));
        check("forced1_gnt1", 64'(gnt1), 64'(1));
        req0 = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_gnt1", 64'(gnt1), 64'(0));
        check("rst_err", 64'(hold_err), 64'(0));
        tick();
        check("rearb_gnt0", 64'(gnt0), 64'(1));
        idle_inputs();
        repeat (4) tick();

        // Release on the very cycle the limit is reached: not an error
        do_reset();
        req0 = 1'b1;
        tick();
        for (int c = 1; c < HOLD; c++) begin rand_beat(0); tick(); end
        req0 = 1'b0; wen0 = 1'b1; waddr0 = 23'h5a5a5; wdata0 = 8'h3c;
        tick();
        check("limit_drop_err", 64'(hold_err), 64'(0));
        idle_inputs();
        repeat (3) tick();

        // Random traffic with occasional reset pulses
        do_reset();
        frame_left[0] = 0; frame_left[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (frame_left[i] > 0) frame_left[i]--;
                else if ($urandom_range(7) == 0) frame_left[i] = int'($urandom_range(60, 1));
            end
            req0 = (frame_left[0] > 0); req1 = (frame_left[1] > 0);
            rand_beat(0); rand_beat(1);
            reset = ($urandom_range(499) == 0);
            tick();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/slink_wr_arb.md
SLINK_WR_ARB -- requirements
Module: slink_wr_arb

Interface
REQ-001 Parameter HOLD_MAX, default 13'd4100, maximum grant duration in clk cycles before forced release.
REQ-002 Parameter GAP_CYC, default 2'd1, number of dead cycles with bus idle between consecutive grants.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req0 / req1  input  1 each  requester 0 (sync receive engine) / requester 1 (local status writer) bus request, held high for the whole frame.
REQ-006 wen0 / wen1  input  1 each  requester write enable.
REQ-007 waddr0 / waddr1  input  23 each  requester AFPGA write address.
REQ-008 wdata0 / wdata1  input  8 each  requester AFPGA write data.
REQ-009 gnt0 / gnt1  output  1 each  grant, registered, never both high.
REQ-010 slink_wen  output  1  AFPGA write enable.
REQ-011 slink_waddr  output  23  AFPGA write address.
REQ-012 slink_data  output  8  AFPGA write data.
REQ-013 hold_err  output  1  sticky flag, set on any forced release.
REQ-014 err_src  output  1  requester index of the most recent forced release.

Function
REQ-015 FSM states: IDLE, GNT0, GNT1, GAP, encoded in 2 bits.
- IDLE: no grant. Bus outputs are driven zero.
REQ-016 IDLE transitions:
- Only req0 high -> GNT0.
- Only req1 high -> GNT1.
- Both high -> the requester not served last (last_id register; reset value 1, so req0 wins first).
REQ-017 GNTn: gntn=1.
- Bus outputs are registered copies of requester n's wen/waddr/wdata, one-cycle latency.
- The other requester's inputs are ignored.
REQ-018 GNTn -> GAP when reqn falls.
- The wen sampled on that same cycle is still forwarded.
- gntn drops the following cycle.
REQ-019 Hold counter (13 bits) clears on grant entry and increments each cycle in GNTn. On reaching HOLD_MAX:
- -> GAP.
- hold_err<=1, err_src<=n.
- slink_wen forced 0 from the next cycle.
REQ-020 GAP:
- slink_wen=0, waddr/data=0, no grant.
- Lasts GAP_CYC cycles, then -> IDLE.
- last_id<=n on GAP entry.
REQ-021 A requester still holding req after forced release is treated as a new request and competes in IDLE per REQ-016.
REQ-022 Simultaneous reqn drop and HOLD_MAX reach: treated as normal release, hold_err unchanged.
REQ-023 wen from a requester whose gnt is low is never forwarded, including the cycle of grant assertion.
- Requesters start writing the cycle after gnt is seen high.
REQ-024 slink_wen is low in every cycle between two grants, so frames never interleave at byte level.
REQ-025 hold_err clears only on reset.

Reset
REQ-026 While reset is high, the FSM is forced to IDLE, overriding any state.
- gnt0=gnt1=0, slink_wen=0, slink_waddr=0, slink_data=0.
- hold_err=0, err_src=0, last_id=1, counters=0.
REQ-027 Reset mid-grant drops the grant in the same cycle.
- Requester inputs are ignored until the first IDLE evaluation after reset falls.

Structure
REQ-028 The state encodings, HOLD_MAX/GAP_CYC defaults, and the done-marker constants (address 23'd2050, data 8'd34) belong in the shared sync-link constants include file.
REQ-029 One sub-module, slink_hold_timer (13-bit counter with clear/enable/terminal flag), is instantiated once.

Verification
REQ-030 req0 alone, 2048 writes at waddr 23'h300002 upward -> gnt0 rises 1 cycle after req0, every byte appears on slink_* 1 cycle later, gnt1 stays 0.
REQ-031 req0 and req1 rise in the same cycle after reset -> GNT0 first; after req0 falls, 1 GAP cycle with slink_wen=0, then gnt1.
REQ-032 req0 held 5000 cycles with HOLD_MAX=4100 -> forced GAP at cycle 4100, hold_err=1, err_src=0; if req1 is pending, GNT1 follows.
REQ-033 req1 asserts wen with waddr 23'd2050, data 8'd34 while gnt0 is active -> nothing forwarded until GNT1; the marker then writes once.
REQ-034 reset pulsed for 1 cycle during GNT1 mid-frame -> next cycle all outputs are zero, hold_err=0, and req0 wins on re-arbitration.
